pixel_scheduler: RTL and testbench
==================================

Name: pixel_scheduler

Overview:
- Frame-level controller for the Mandelbrot pixel pipeline.
- Walks the screen in raster order and dispatches pixel coordinates round-robin to NCORES iteration cores.
- Captures each core's escape depth and retires results strictly in raster order through the shared colour-LUT stage (depth in, 24-bit colour out one cycle after enable).
- Emits a back-pressured video stream with start-of-frame and end-of-line markers.

Parameters:
NCORES, 4, number of iteration cores (2..8)
WIDTH, 640, pixels per line
HEIGHT, 480, lines per frame

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame (ignored unless IDLE)
max_iter  in  10  iteration limit; latched on accepted start
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse after last pixel handshaked
core_start  out  NCORES  one-hot one-cycle dispatch pulse
core_x  out  10  pixel x; valid with core_start
core_y  out  10  pixel y; valid with core_start
core_max_iter  out  10  latched max_iter, stable for whole frame
core_done  in  NCORES  per-core one-cycle completion pulse
core_depth  in  10*NCORES  per-core depth; slice k valid with core_done[k]
lut_en  out  1  colour-stage enable, one cycle per retired pixel
lut_depth  out  10  depth presented with lut_en
lut_color  in  24  colour stage output; valid cycle after lut_en
out_data  out  24  pixel colour
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_user  out  1  high on pixel (0,0) beat
out_last  out  1  high on x==WIDTH-1 beats

Behaviour:
- Reset: FSM IDLE; busy, frame_done, core_start, lut_en, out_valid, out_user, out_last = 0; core_x, core_y, lut_depth, out_data, core_max_iter = 0; all per-core slots FREE; pointers and counters = 0.
- FSM IDLE -> RUN on start; RUN -> DRAIN when dispatch counter passes (WIDTH-1, HEIGHT-1); DRAIN -> DONE when last pixel handshaked on stream; DONE -> IDLE next cycle with frame_done = 1 for that cycle.
- Per-core slot states: FREE -> BUSY on dispatch; BUSY -> HELD on core_done (depth captured into slot register); HELD -> FREE when retired.
- Dispatch (RUN only): pointer d. If slot[d] FREE, pulse core_start[d] with current (x, y), advance x (wrap to 0 at WIDTH-1, increment y), d = (d+1) mod NCORES. Max one dispatch per cycle. Stall (no pulse) while slot[d] not FREE.
- Retire: pointer r. If slot[r] HELD and credit available, assert lut_en with lut_depth = slot depth, slot[r] -> FREE, r = (r+1) mod NCORES. Max one per cycle. Retirement order therefore equals raster order.
- A slot freed by retire may be re-dispatched the same cycle.
- Output buffer: 2-entry FIFO. Cycle after lut_en, lut_color is written together with that pixel's user/last flags, which are computed from a separate retire x/y counter.
- Credit: lut_en permitted only when (FIFO occupancy + in-flight lut_en) < 2. Output never drops or duplicates a pixel under any out_ready pattern.
- out_valid = FIFO non-empty; head pops on out_valid & out_ready. Data and flags are held stable while valid & !ready.
- core_done for a slot not BUSY: ignored. Simultaneous core_done on several cores: all captured the same cycle.
- start while busy: ignored; max_iter is not re-latched.
- Reset mid-frame: all state returns to reset values immediately, the stream is abandoned, and cores are not notified.
- Width rules: x and y counters are 10 bits; WIDTH and HEIGHT must be ≤ 1024. Pixel count is WIDTH*HEIGHT, tracked by the retire counters.

Test Plan:
- WIDTH=4, HEIGHT=2, NCORES=2, cores complete in 3 cycles, out_ready=1 -> 8 beats in raster order; out_user on beat 0 only; out_last on beats 3 and 7; frame_done 1 cycle after beat 7; core_start alternates 01, 10.
- Cores with unequal latency (core0 20 cycles, core1 2 cycles) -> stream order still raster; core1 stalls in HELD until core0 retires.
- out_ready toggled randomly, including 30 cycles low -> lut_en never asserted with 2 entries committed; no lost or duplicate pixels; out_data stable while stalled.
- max_iter=100 latched; start pulsed again mid-frame with max_iter=5 -> ignored; core_max_iter stays 100; busy stays high.
- rst_n dropped mid-frame at pixel 3 -> outputs zero asynchronously; a new start after release produces a full frame beginning with out_user=1 at (0,0).
- Spurious core_done on a FREE core -> no capture, no extra output beat.

Source files
------------

// File: rtl/pixel_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pixel_scheduler
// Description : Frame controller for the Mandelbrot pixel pipeline. It walks
//               the screen in raster order and hands coordinates round-robin
//               to NCORES iteration cores. It collects their escape depths and
//               retires them in raster order through the colour-LUT stage.
//               The result leaves as a back-pressured video stream with
//               start-of-frame (out_user) and end-of-line (out_last) flags.
// Ports       : clk, rst_n                  clock, async active-low reset
//               start, max_iter             frame request, iteration limit
//               busy, frame_done            frame status
//               core_start/x/y/max_iter     dispatch to cores
//               core_done, core_depth       completion from cores
//               lut_en, lut_depth,lut_color colour stage (1-cycle latency)
//               out_data/valid/ready/user/last  video stream
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_scheduler #(
  parameter int NCORES = 4,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [9:0]           max_iter,
  output logic                 busy,
  output logic                 frame_done,
  output logic [NCORES-1:0]    core_start,
  output logic [9:0]           core_x,
  output logic [9:0]           core_y,
  output logic [9:0]           core_max_iter,
  input  logic [NCORES-1:0]    core_done,
  input  logic [10*NCORES-1:0] core_depth,
  output logic                 lut_en,
  output logic [9:0]           lut_depth,
  input  logic [23:0]          lut_color,
  output logic [23:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_user,
  output logic                 out_last
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [PW-1:0] C_LAST_CORE = PW'(NCORES - 1);
  localparam logic [9:0]    C_X_LAST    = 10'(WIDTH - 1);
  localparam logic [9:0]    C_Y_LAST    = 10'(HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;
  typedef enum logic [1:0] {SL_FREE = 2'd0, SL_BUSY = 2'd1, SL_HELD = 2'd2} slot_t;

  state_t            r_state;
  slot_t             r_slot       [NCORES];
  logic [9:0]        r_slot_depth [NCORES];
  logic [PW-1:0]     r_dptr, r_rptr;
  logic [9:0]        r_x, r_y;          // next pixel to dispatch
  logic [9:0]        r_rx, r_ry;        // next pixel to retire
  logic              r_busy, r_frame_done;
  logic [NCORES-1:0] r_core_start;
  logic [9:0]        r_core_x, r_core_y, r_max_iter;
  logic              r_lut_en;
  logic [9:0]        r_lut_depth;
  // Flags travel alongside the pixel: e_* during the lut_en cycle,
  // c_* during the cycle lut_color is valid and gets written.
  logic              r_e_user, r_e_last, r_e_eof;
  logic              r_c_valid, r_c_user, r_c_last, r_c_eof;
  logic [23:0]       r_fifo_data [2];
  logic              r_fifo_user [2];
  logic              r_fifo_last [2];
  logic              r_fifo_eof  [2];
  logic              r_wr, r_rd;
  logic [1:0]        r_count;

  logic              w_pop, w_credit, w_retire, w_dispatch;
  logic [2:0]        w_inflight;

  // Committed entries plus both pixels still inside the colour stage must
  // fit in the 2-entry buffer, so a stalled stream can never overflow it.
  assign w_inflight = {1'b0, r_count} + {2'b00, r_lut_en} + {2'b00, r_c_valid};
  assign w_credit   = (w_inflight < 3'd2);
  assign w_pop      = (r_count != 2'd0) && out_ready;
  assign w_retire   = (r_slot[r_rptr] == SL_HELD) && w_credit;
  // A slot being retired this cycle counts as free for dispatch.
  assign w_dispatch = (r_state == S_RUN) &&
                      ((r_slot[r_dptr] == SL_FREE) || (w_retire && (r_rptr == r_dptr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_dptr       <= '0;
      r_rptr       <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_rx         <= '0;
      r_ry         <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_core_start <= '0;
      r_core_x     <= '0;
      r_core_y     <= '0;
      r_max_iter   <= '0;
      r_lut_en     <= 1'b0;
      r_lut_depth  <= '0;
      r_e_user     <= 1'b0;
      r_e_last     <= 1'b0;
      r_e_eof      <= 1'b0;
      r_c_valid    <= 1'b0;
      r_c_user     <= 1'b0;
      r_c_last     <= 1'b0;
      r_c_eof      <= 1'b0;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      r_count      <= '0;
      for (int k = 0; k < NCORES; k++) begin
        r_slot[k]       <= SL_FREE;
        r_slot_depth[k] <= '0;
      end
      for (int k = 0; k < 2; k++) begin
        r_fifo_data[k] <= '0;
        r_fifo_user[k] <= 1'b0;
        r_fifo_last[k] <= 1'b0;
        r_fifo_eof[k]  <= 1'b0;
      end
    end else begin
      r_core_start <= '0;
      r_frame_done <= 1'b0;
      r_lut_en     <= w_retire;
      r_c_valid    <= r_lut_en;
      r_c_user     <= r_e_user;
      r_c_last     <= r_e_last;
      r_c_eof      <= r_e_eof;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_RUN;
            r_busy     <= 1'b1;
            r_max_iter <= max_iter;
            r_x        <= '0;
            r_y        <= '0;
            r_rx       <= '0;
            r_ry       <= '0;
            r_dptr     <= '0;
            r_rptr     <= '0;
          end
        end
        S_RUN: begin
          if (w_dispatch && (r_x == C_X_LAST) && (r_y == C_Y_LAST)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pop && r_fifo_eof[r_rd]) begin
            r_state      <= S_DONE;
            r_frame_done <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_dispatch) begin
        r_core_start <= NCORES'(1) << r_dptr;
        r_core_x     <= r_x;
        r_core_y     <= r_y;
        r_dptr       <= (r_dptr == C_LAST_CORE) ? '0 : r_dptr + 1'b1;
        if (r_x == C_X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == C_Y_LAST) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end

      if (w_retire) begin
        r_lut_depth <= r_slot_depth[r_rptr];
        r_e_user    <= (r_rx == '0) && (r_ry == '0);
        r_e_last    <= (r_rx == C_X_LAST);
        r_e_eof     <= (r_rx == C_X_LAST) && (r_ry == C_Y_LAST);
        r_rptr      <= (r_rptr == C_LAST_CORE) ? '0 : r_rptr + 1'b1;
        if (r_rx == C_X_LAST) begin
          r_rx <= '0;
          r_ry <= r_ry + 1'b1;
        end else begin
          r_rx <= r_rx + 1'b1;
        end
      end

      // Slot updates; the three transitions need disjoint source states,
      // except retire+dispatch on one slot where dispatch must win.
      for (int k = 0; k < NCORES; k++) begin
        if (core_done[k] && (r_slot[k] == SL_BUSY)) begin
          r_slot[k]       <= SL_HELD;
          r_slot_depth[k] <= core_depth[k*10 +: 10];
        end
        if (w_retire && (r_rptr == PW'(k)))   r_slot[k] <= SL_FREE;
        if (w_dispatch && (r_dptr == PW'(k))) r_slot[k] <= SL_BUSY;
      end

      if (r_c_valid) begin
        r_fifo_data[r_wr] <= lut_color;
        r_fifo_user[r_wr] <= r_c_user;
        r_fifo_last[r_wr] <= r_c_last;
        r_fifo_eof[r_wr]  <= r_c_eof;
        r_wr              <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;

      case ({r_c_valid, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign core_start    = r_core_start;
  assign core_x        = r_core_x;
  assign core_y        = r_core_y;
  assign core_max_iter = r_max_iter;
  assign lut_en        = r_lut_en;
  assign lut_depth     = r_lut_depth;
  assign out_valid     = (r_count != 2'd0);
  assign out_data      = r_fifo_data[r_rd];
  assign out_user      = out_valid & r_fifo_user[r_rd];
  assign out_last      = out_valid & r_fifo_last[r_rd];

endmodule
`default_nettype wire

// File: tb/tb_pixel_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pixel_scheduler
// Description : Self-checking bench for pixel_scheduler on a 4x2 screen with
//               two cores. Core and colour-stage models drive the DUT, the
//               stream is captured and compared against a raster-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_scheduler;
  localparam int NC = 2, W = 4, H = 2, NPIX = W * H;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [9:0] max_iter = '0;
  logic busy, frame_done, lut_en, out_valid, out_user, out_last;
  logic [NC-1:0] core_start;
  logic [9:0] core_x, core_y, core_max_iter, lut_depth;
  logic [NC-1:0] core_done = '0;
  logic [10*NC-1:0] core_depth = '0;
  logic [23:0] lut_color = '0, out_data;
  logic out_ready = 1'b0;

  pixel_scheduler #(.NCORES(NC), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_iter(max_iter),
    .busy(busy), .frame_done(frame_done), .core_start(core_start),
    .core_x(core_x), .core_y(core_y), .core_max_iter(core_max_iter),
    .core_done(core_done), .core_depth(core_depth),
    .lut_en(lut_en), .lut_depth(lut_depth), .lut_color(lut_color),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_user(out_user), .out_last(out_last));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int ready_mode = 0, low_cnt = 0;
  int lat [NC];
  bit lat_rand = 0, spur_en = 0;
  int cnt [NC];
  logic [9:0] cx [NC], cy [NC];
  logic [9:0] prev_depth = '0;
  int cyc = 0, issued = 0, pops = 0, credit_viol = 0, stab_viol = 0;
  int fd_cnt = 0, fd_cyc = 0, last_pop_cyc = 0;
  logic [25:0] beats [$];
  logic [NC+19:0] disp [$];
  bit stalled = 0;
  logic [25:0] held = '0;

  function automatic logic [9:0] depth_of(input int x, input int y, input int mi);
    return 10'((x * 37 + y * 101 + mi * 3) % 1024);
  endfunction

  function automatic logic [23:0] color_of(input logic [9:0] d);
    return {d[7:0], ~d[9:2], d[9:8], d[5:0]};
  endfunction

  // Environment: colour stage, cores, stream sink, and passive monitor.
  always @(negedge clk) begin
    cyc++;
    lut_color  = color_of(prev_depth);
    prev_depth = lut_depth;

    core_done = '0;
    for (int k = 0; k < NC; k++) begin
      if (cnt[k] > 0) begin
        cnt[k]--;
        if (cnt[k] == 0) begin
          core_done[k] = 1'b1;
          core_depth[10*k +: 10] = depth_of(int'(cx[k]), int'(cy[k]), int'(core_max_iter));
        end
      end
      if (core_start[k]) begin
        cnt[k] = lat_rand ? int'($urandom_range(1, 12)) : lat[k];
        cx[k]  = core_x;
        cy[k]  = core_y;
      end else if (spur_en && cnt[k] == 0 && !core_done[k] && $urandom_range(0, 3) == 0) begin
        core_done[k] = 1'b1;
        core_depth[10*k +: 10] = 10'h3ff;
      end
    end

    if (low_cnt > 0) begin
      out_ready = 1'b0;
      low_cnt--;
    end else if (ready_mode == 0) out_ready = 1'b1;
    else out_ready = ($urandom_range(0, 1) == 1);

    if (rst_n) begin
      if (lut_en) begin
        if (issued - pops >= 2) credit_viol++;
        issued++;
      end
      if (stalled && (!out_valid || {out_data, out_user, out_last} !== held)) stab_viol++;
      stalled = out_valid && !out_ready;
      held    = {out_data, out_user, out_last};
      if (out_valid && out_ready) begin
        beats.push_back({out_data, out_user, out_last});
        pops++;
        last_pop_cyc = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (core_start != '0) disp.push_back({core_start, core_x, core_y});
    end else begin
      stalled = 0;
    end
  end

  task automatic start_frame(input int mi);
    @(posedge clk);
    beats.delete();
    disp.delete();
    issued = 0; pops = 0; fd_cnt = 0; credit_viol = 0; stab_viol = 0;
    @(negedge clk);
    start = 1'b1;
    max_iter = 10'(mi);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while (fd_cnt == 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (fd_cnt == 0) begin
      fails++;
      $display("FAIL %s frame_done: got none within %0d cycles, required one pulse", name, bound);
    end
    @(negedge clk);
  endtask

  task automatic check_stream(input string name, input int mi);
    logic [25:0] exp;
    tests++;
    if (beats.size() != NPIX) begin
      fails++;
      $display("FAIL %s beat_count: got %0d, required %0d", name, beats.size(), NPIX);
    end
    for (int i = 0; i < NPIX && i < beats.size(); i++) begin
      exp = {color_of(depth_of(i % W, i / W, mi)), (i == 0), ((i % W) == W - 1)};
      tests++;
      if (beats[i] !== exp) begin
        fails++;
        $display("FAIL %s beat%0d {data,user,last}: got %h, required %h", name, i, beats[i], exp);
      end
    end
  endtask

  task automatic check_flow(input string name);
    tests++;
    if (credit_viol != 0) begin
      fails++;
      $display("FAIL %s credit: got %0d lut_en with 2 outstanding, required 0", name, credit_viol);
    end
    tests++;
    if (stab_viol != 0) begin
      fails++;
      $display("FAIL %s stall_stability: got %0d changes while stalled, required 0", name, stab_viol);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, frame_done, core_start, lut_en, out_valid, out_user, out_last} !== '0) begin
      fails++;
      $display("FAIL reset ctrl: got %b, required 0",
               {busy, frame_done, core_start, lut_en, out_valid, out_user, out_last});
    end
    tests++;
    if ({core_x, core_y, lut_depth, out_data, core_max_iter} !== '0) begin
      fails++;
      $display("FAIL reset data: got %h, required 0", {core_x, core_y, lut_depth, out_data, core_max_iter});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset idle: got busy=%b valid=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_basic_frame();
    logic [NC+19:0] e;
    lat[0] = 3; lat[1] = 3; lat_rand = 0; spur_en = 0; ready_mode = 0;
    start_frame(37);
    wait_done("basic", 300);
    check_stream("basic", 37);
    tests++;
    if (disp.size() != NPIX) begin
      fails++;
      $display("FAIL basic dispatch_count: got %0d, required %0d", disp.size(), NPIX);
    end
    for (int i = 0; i < NPIX && i < disp.size(); i++) begin
      e = {NC'(1 << (i % NC)), 10'(i % W), 10'(i / W)};
      tests++;
      if (disp[i] !== e) begin
        fails++;
        $display("FAIL basic dispatch%0d {start,x,y}: got %h, required %h", i, disp[i], e);
      end
    end
    tests++;
    if (fd_cnt != 1 || fd_cyc - last_pop_cyc != 1) begin
      fails++;
      $display("FAIL basic frame_done_timing: got %0d pulses %0d cycles after last beat, required 1 and 1",
               fd_cnt, fd_cyc - last_pop_cyc);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL basic busy_after: got %b, required 0", busy);
    end
  endtask

  task automatic test_unequal_latency();
    lat[0] = 20; lat[1] = 2; lat_rand = 0; spur_en = 1; ready_mode = 0;
    start_frame(200);
    wait_done("unequal", 600);
    check_stream("unequal", 200);
    check_flow("unequal");
  endtask

  task automatic test_backpressure();
    lat_rand = 1; spur_en = 1; ready_mode = 1;
    start_frame(511);
    repeat (6) @(posedge clk);
    low_cnt = 30;
    wait_done("backpressure", 2000);
    check_stream("backpressure", 511);
    check_flow("backpressure");
  endtask

  task automatic test_start_ignored();
    lat[0] = 3; lat[1] = 5; lat_rand = 0; spur_en = 0; ready_mode = 0;
    start_frame(100);
    repeat (3) @(negedge clk);
    start = 1'b1;
    max_iter = 10'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || core_max_iter !== 10'd100) begin
      fails++;
      $display("FAIL restart busy/max_iter: got %b/%0d, required 1/100", busy, core_max_iter);
    end
    wait_done("restart", 400);
    check_stream("restart", 100);
    repeat (20) @(negedge clk);
    tests++;
    if (fd_cnt != 1 || busy !== 1'b0 || beats.size() != NPIX) begin
      fails++;
      $display("FAIL restart extra_frame: got done=%0d busy=%b beats=%0d, required 1 0 %0d",
               fd_cnt, busy, beats.size(), NPIX);
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    int b0;
    lat[0] = 3; lat[1] = 3; lat_rand = 0; spur_en = 0; ready_mode = 0;
    start_frame(77);
    while (pops < 3 && n < 300) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (pops < 3) begin
      fails++;
      $display("FAIL midreset reach_pixel3: got %0d beats, required 3", pops);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, out_valid, lut_en, core_start, out_user, out_last} !== '0 ||
        {out_data, core_max_iter} !== '0) begin
      fails++;
      $display("FAIL midreset async_zero: got ctrl=%b data=%h, required 0",
               {busy, out_valid, lut_en, core_start, out_user, out_last}, {out_data, core_max_iter});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b0 = beats.size();
    repeat (40) @(negedge clk);
    tests++;
    if (beats.size() != b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset quiet: got %0d new beats busy=%b, required 0 0", beats.size() - b0, busy);
    end
    start_frame(77);
    wait_done("midreset", 400);
    check_stream("midreset", 77);
  endtask

  task automatic test_back_to_back();
    int mi;
    lat_rand = 1; spur_en = 1; ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      mi = int'($urandom_range(1, 1023));
      start_frame(mi);
      wait_done("b2b", 2000);
      check_stream("b2b", mi);
      check_flow("b2b");
    end
  endtask

  initial begin
    for (int k = 0; k < NC; k++) begin
      lat[k] = 3;
      cnt[k] = 0;
      cx[k]  = '0;
      cy[k]  = '0;
    end
    test_reset();
    test_basic_frame();
    test_unequal_latency();
    test_backpressure();
    test_start_ignored();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
